// File: rtl/pipe_stall_ctrl.sv
// Central stall/flush controller: pipeline-register enables, flushes and PC load,
// plus the redirect-while-fetching hold (RUN/DROP) and a saturating stall counter.
module pipe_stall_ctrl #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              ACLK,
  input  logic              ARESETn,
  input  logic              hz_pc_write,
  input  logic              hz_if_id_write,
  input  logic              hz_id_flush,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_target,
  input  logic              im_stall,
  input  logic              dm_stall,
  output logic              pc_en,
  output logic              pc_redirect,
  output logic [ADDR_W-1:0] pc_target,
  output logic              if_id_en,
  output logic              if_id_flush,
  output logic              id_ex_en,
  output logic              id_ex_flush,
  output logic              ex_mem_en,
  output logic              mem_wb_en,
  output logic              drop_active,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic {
    RUN  = 1'b0,
    DROP = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] tgt_q, tgt_d;

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q <= RUN;
      tgt_q   <= '0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
    end
  end

  // Next state and all pipeline controls; hazard inputs only matter in the RUN fall-through case
  always_comb begin
    state_d     = state_q;
    tgt_d       = tgt_q;
    pc_en       = 1'b0;
    pc_redirect = 1'b0;
    if_id_en    = 1'b0;
    if_id_flush = 1'b0;
    id_ex_en    = 1'b0;
    id_ex_flush = 1'b0;
    ex_mem_en   = 1'b0;
    mem_wb_en   = 1'b0;
    pc_target   = (state_q == DROP) ? tgt_q : br_target;

    if (!ARESETn) begin
      pc_target = '0;
    end else if (dm_stall) begin
      // Whole pipe frozen; any redirect in EX is re-seen once the data access returns
    end else begin
      unique case (state_q)
        RUN: begin
          id_ex_en  = 1'b1;
          ex_mem_en = 1'b1;
          mem_wb_en = 1'b1;
          if (br_taken && !im_stall) begin
            pc_en       = 1'b1;
            pc_redirect = 1'b1;
            if_id_en    = 1'b1;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
          end else if (br_taken) begin
            id_ex_flush = 1'b1;
            tgt_d       = br_target;
            state_d     = DROP;
          end else if (im_stall) begin
            id_ex_flush = 1'b1;
          end else begin
            pc_en       = hz_pc_write;
            if_id_en    = hz_if_id_write;
            id_ex_flush = hz_id_flush;
          end
        end
        DROP: begin
          id_ex_en    = 1'b1;
          id_ex_flush = 1'b1;
          ex_mem_en   = 1'b1;
          mem_wb_en   = 1'b1;
          if (!im_stall) begin
            // Stale fetch returned: discard it and load the held target
            pc_en       = 1'b1;
            pc_redirect = 1'b1;
            if_id_en    = 1'b1;
            if_id_flush = 1'b1;
            state_d     = RUN;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  assign drop_active = (state_q == DROP);

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      stall_cnt <= '0;
    end else if (!pc_en && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: doc/pipe_stall_ctrl.md
# pipe_stall_ctrl

- Central stall/flush controller for the 5-stage CPU core.
- Consumes the ID hazard detector's stall requests, the EX branch/jump redirect, and the AXI-side instruction and data memory wait signals.
- Drives every pipeline-register enable and flush, plus the PC load.
- Owns the only sequential piece of control: a redirect that arrives while an instruction fetch is still in flight on AXI is held until that fetch completes, and the returning instruction is then discarded.

## Interface
Parameters:
- ADDR_W, 32, width of PC/target addresses
- CNT_W, 32, width of the stall-cycle counter

Ports:
- ACLK  in  1  core clock; all state on rising edge
- ARESETn  in  1  asynchronous, active-low reset
- hz_pc_write  in  1  from hazard detector; 0 = hold PC
- hz_if_id_write  in  1  from hazard detector; 0 = hold IF/ID
- hz_id_flush  in  1  from hazard detector; 1 = insert bubble into ID/EX
- br_taken  in  1  EX stage resolved a taken branch/jump
- br_target  in  ADDR_W  redirect address, valid with br_taken
- im_stall  in  1  IF fetch outstanding (AXI read not yet returned)
- dm_stall  in  1  MEM access outstanding
- pc_en  out  1  PC register load enable
- pc_redirect  out  1  PC loads pc_target instead of sequential PC
- pc_target  out  ADDR_W  redirect address to PC mux
- if_id_en  out  1  IF/ID load enable
- if_id_flush  out  1  IF/ID loads NOP (when if_id_en=1)
- id_ex_en  out  1  ID/EX load enable
- id_ex_flush  out  1  ID/EX loads NOP (when id_ex_en=1)
- ex_mem_en  out  1  EX/MEM load enable
- mem_wb_en  out  1  MEM/WB load enable
- drop_active  out  1  state is DROP
- stall_cnt  out  CNT_W  saturating count of cycles with pc_en=0

## Operation
Registered state:
- FSM: RUN, DROP
- tgt_q[ADDR_W]
- stall_cnt

All outputs are combinational from state and inputs.

A redirect is accepted only when `br_taken=1 && dm_stall=0`. While dm_stall is high the branch is frozen in EX, so the redirect is simply re-seen later.

RUN, evaluated in priority order:
1. **dm_stall=1:** all enables 0, all flushes 0, pc_redirect 0. Whole pipe frozen.
2. **Accepted redirect, im_stall=0:** pc_en=1, pc_redirect=1, pc_target=br_target, if_id_en=1, if_id_flush=1, id_ex_en=1, id_ex_flush=1, ex_mem_en=mem_wb_en=1.
3. **Accepted redirect, im_stall=1:** tgt_q<=br_target, next state DROP; pc_en=0, if_id_en=0, id_ex_en=1, id_ex_flush=1, ex_mem_en=mem_wb_en=1.
4. **im_stall=1:** pc_en=0, if_id_en=0, id_ex_en=1, id_ex_flush=1, later stages enabled.
5. **Otherwise:** pc_en=hz_pc_write, if_id_en=hz_if_id_write, id_ex_en=1, id_ex_flush=hz_id_flush, ex_mem_en=mem_wb_en=1, pc_redirect=0.

Hazard inputs are ignored in cases 1-4.

DROP:
- pc_target=tgt_q at all times.
- br_taken is ignored: EX holds a bubble.
- **dm_stall=1:** all enables 0, stay in DROP.
- **im_stall=1, dm_stall=0:** pc_en=0, if_id_en=0, id_ex_en=1, id_ex_flush=1, ex_mem_en=mem_wb_en=1.
- **im_stall=0, dm_stall=0:** the stale fetch has returned. pc_en=1, pc_redirect=1, if_id_en=1, if_id_flush=1, id_ex_en=1, id_ex_flush=1, ex_mem_en=mem_wb_en=1, next state RUN.

stall_cnt:
- +1 on each clock edge where pc_en=0 and ARESETn=1.
- Saturates at all-ones; no wrap.

## Timing
- Control outputs respond combinationally in the same cycle as their inputs; zero latency.
- The DROP entry/exit and tgt_q capture take effect at the next rising edge.
- Minimum DROP residency is 1 cycle. A redirect during a fetch costs (remaining im_stall cycles + 1) before the target enters IF.
- While ARESETn=0:
  - state=RUN, tgt_q=0, stall_cnt=0
  - all enables 0, all flushes 0, pc_redirect=0, drop_active=0, pc_target=0
- Reset asserted mid-DROP abandons the saved target; the state is RUN after release.
- Simultaneous dm_stall and im_stall: dm_stall rule wins, and no state change occurs.
- Simultaneous br_taken and a hazard request: the redirect wins, and the hazard is dropped because the flushed instruction no longer needs it.

## Test plan
- **Reset:** hold ARESETn=0 for 3 cycles with random inputs. Expect all enables/flushes 0 and stall_cnt=0; state RUN after release.
- **Load-use hazard:** hz_pc_write=0, hz_if_id_write=0, hz_id_flush=1 for 1 cycle, no mem stalls. Expect pc_en=0, if_id_en=0, id_ex_flush=1, ex_mem_en=1, and stall_cnt 0→1.
- **Redirect with idle fetch:** br_taken=1, br_target=0x0000_0100, im_stall=0. Expect the same cycle pc_redirect=1, pc_target=0x100, if_id_flush=1, id_ex_flush=1, and no DROP.
- **Redirect during fetch:** br_taken=1, br_target=0x0000_0200 with im_stall=1 held 3 more cycles. Expect drop_active=1 for those 3 cycles plus the completion cycle, pc_en=0 throughout DROP, then pc_en=1, pc_redirect=1, pc_target=0x200, if_id_flush=1, then RUN.
- **dm_stall priority:** assert dm_stall=1 together with br_taken=1 and im_stall=1 for 4 cycles. Expect all enables 0, no DROP entry, and tgt_q unchanged. Deassert dm_stall: the redirect is accepted then.
- **Counter saturation:** force stall_cnt near max (CNT_W=4 build), hold pc_en=0 for 20 cycles. Expect it to stop at 4'hF.
